uart_word_transmit: RTL

UART_WORD_TRANSMIT -- requirements
Module: uart_word_transmit

---
 rtl/uart_word_transmit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_word_transmit.sv
// Word-level 8N1 UART transmitter: sends an optional sync header followed by
// NUM_BYTES data bytes back to back, then pulses done_out for one cycle.
module uart_word_transmit #(
  parameter int          INPUT_CLOCK_FREQ = 100_000_000,
  parameter int          BAUD_RATE        = 115_200,
  parameter int          NUM_BYTES        = 2,
  parameter int          MSB_FIRST        = 1,
  parameter int          SYNC_EN          = 0,
  parameter logic [7:0]  SYNC_BYTE        = 8'hA5
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [8*NUM_BYTES-1:0] data_in,
  input  logic                   trigger_in,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   tx_wire_out
);

  localparam int CPB    = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int SYNC_N = (SYNC_EN != 0) ? 1 : 0;
  localparam int FRAMES = NUM_BYTES + SYNC_N;
  localparam int CNT_W  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int FR_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  if (CPB < 2) begin : g_cpb_check
    $error("uart_word_transmit: clocks per bit must be at least 2");
  end
  if (NUM_BYTES < 1 || NUM_BYTES > 8) begin : g_bytes_check
    $error("uart_word_transmit: NUM_BYTES must be within 1..8");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [FR_W-1:0]        frame_q, frame_d;
  logic [8*NUM_BYTES-1:0] word_q, word_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic [7:0]             cur_byte;
  logic                   baud_end;

  // Frame 0 is the header when enabled; data frames follow in MSB_FIRST order.
  always_comb begin
    cur_byte = SYNC_BYTE;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (frame_q == FR_W'(i + SYNC_N)) begin
        cur_byte = word_q[8*((MSB_FIRST != 0) ? (NUM_BYTES - 1 - i) : i) +: 8];
      end
    end
  end

  assign baud_end = (cnt_q == CNT_W'(CPB - 1));

  // tx_d is the value of the line for the next bit, so tx_q changes exactly
  // on bit boundaries and comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    word_d  = word_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (trigger_in) begin
          state_d = START;
          word_d  = data_in;
          cnt_d   = '0;
          bit_d   = '0;
          frame_d = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = cur_byte[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          cnt_d = '0;
          if (frame_q == FR_W'(FRAMES - 1)) begin
            state_d = IDLE;
            frame_d = '0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            state_d = START;
            frame_d = frame_q + 1'b1;
            tx_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign busy_out    = (state_q != IDLE);
  assign done_out    = done_q;
  assign tx_wire_out = tx_q;

endmodule
